// File: rtl/mem_stage_lsu_if.sv
// Shared operation encoding and the data-memory request/grant/response bus
// between the memory stage (master) and data memory (slave).
package mem_stage_lsu_pkg;
  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_SLTU, ALU_LUI,
    ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU,
    ALU_SB, ALU_SH, ALU_SW
  } alu_ctrl_e;
endpackage

interface mem_stage_lsu_if #(parameter int XLEN = 32);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [3:0]      wstrb;
  logic [XLEN-1:0] wdata;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (output req, we, addr, wstrb, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wstrb, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_stage_lsu.sv
// RISC-V memory stage: loads/stores over a req/gnt/rvalid port with lane
// steering and load extension; registers the MEM-WB record and stalls upstream.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  tb_update_i,
  output logic                  tb_update_o,
  input  logic [31:0]           pcM_i,
  input  logic [31:0]           instrM_i,
  input  alu_ctrl_e             operationM_i,
  input  logic [31:0]           rdM_data_i,
  input  logic [4:0]            rdM_addr_i,
  input  logic                  rdM_wr_ena_i,
  input  logic                  memM_wr_ena_i,
  input  logic [31:0]           memM_addr_i,
  input  logic [31:0]           memM_wr_data_i,
  output logic [31:0]           forwM_data_o,
  output logic                  stall_o,
  mem_stage_lsu_if.master       dmem,
  output logic [31:0]           pcW_o,
  output logic [31:0]           instrW_o,
  output logic [31:0]           rdW_data_o,
  output logic [4:0]            rdW_addr_o,
  output logic                  rdW_wr_ena_o,
  output logic                  misaligned_o
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP} state_e;

  state_e      r_state, w_state_nxt;
  logic        w_is_load, w_is_store, w_misaligned, w_access;
  logic        w_req, w_stall;
  logic [1:0]  w_off;
  logic [31:0] r_pcW, r_instrW, r_rdW_data;
  logic [4:0]  r_rdW_addr;
  logic        r_rdW_wr_ena, r_misaligned, r_tb_update;

  function automatic logic [31:0] f_load_ext(alu_ctrl_e op, logic [1:0] off, logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (op)
      ALU_LB:  f_load_ext = {{24{b[7]}}, b};
      ALU_LBU: f_load_ext = {24'h0, b};
      ALU_LH:  f_load_ext = {{16{h[15]}}, h};
      ALU_LHU: f_load_ext = {16'h0, h};
      default: f_load_ext = w;
    endcase
  endfunction

  function automatic logic [3:0] f_wstrb(alu_ctrl_e op, logic [1:0] off);
    case (op)
      ALU_SB:  f_wstrb = 4'b0001 << off;
      ALU_SH:  f_wstrb = off[1] ? 4'b1100 : 4'b0011;
      ALU_SW:  f_wstrb = 4'b1111;
      default: f_wstrb = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] f_wdata(alu_ctrl_e op, logic [31:0] d);
    case (op)
      ALU_SB:  f_wdata = {4{d[7:0]}};
      ALU_SH:  f_wdata = {2{d[15:0]}};
      default: f_wdata = d;
    endcase
  endfunction

  assign w_off        = memM_addr_i[1:0];
  assign w_is_load    = operationM_i inside {ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU};
  assign w_is_store   = operationM_i inside {ALU_SB, ALU_SH, ALU_SW};
  assign w_misaligned = ((operationM_i inside {ALU_LH, ALU_LHU, ALU_SH}) && w_off[0]) ||
                        ((operationM_i inside {ALU_LW, ALU_SW}) && (w_off != 2'b00));
  assign w_access     = (w_is_load || w_is_store) && !w_misaligned;

  // Bus fields come straight from the held EX-MEM inputs, so they stay stable while stalled
  assign dmem.req      = w_req;
  assign dmem.we       = w_is_store;
  assign dmem.addr     = {memM_addr_i[31:2], 2'b00};
  assign dmem.wstrb    = f_wstrb(operationM_i, w_off);
  assign dmem.wdata    = f_wdata(operationM_i, memM_wr_data_i);
  assign forwM_data_o  = rdM_data_i;
  assign stall_o       = w_stall;

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_stall     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_access) begin
          w_req = 1'b1;
          if (!(w_is_store && dmem.gnt)) begin
            w_stall     = 1'b1;
            w_state_nxt = (dmem.gnt) ? WAIT_RSP : WAIT_GNT;
          end
        end
      end
      WAIT_GNT: begin
        w_req   = 1'b1;
        w_stall = 1'b1;
        if (dmem.gnt) begin
          if (w_is_store) begin
            w_stall     = 1'b0;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = WAIT_RSP;
          end
        end
      end
      WAIT_RSP: begin
        if (dmem.rvalid) w_state_nxt = IDLE;
        else             w_stall     = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // MEM-WB register: the record retires whenever no stall is raised
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_pcW        <= RESET_PC;
      r_instrW     <= NOP_INSTR;
      r_rdW_data   <= '0;
      r_rdW_addr   <= '0;
      r_rdW_wr_ena <= 1'b0;
      r_misaligned <= 1'b0;
      r_tb_update  <= 1'b0;
    end else if (w_stall) begin
      r_instrW     <= NOP_INSTR;
      r_rdW_wr_ena <= 1'b0;
      r_misaligned <= 1'b0;
      r_tb_update  <= 1'b0;
    end else begin
      r_pcW        <= pcM_i;
      r_instrW     <= instrM_i;
      r_rdW_addr   <= rdM_addr_i;
      r_tb_update  <= tb_update_i;
      r_misaligned <= w_misaligned;
      r_rdW_wr_ena <= rdM_wr_ena_i && !w_misaligned && !w_is_store;
      if (w_misaligned)   r_rdW_data <= '0;
      else if (w_is_load) r_rdW_data <= f_load_ext(operationM_i, w_off, dmem.rdata);
      else                r_rdW_data <= rdM_data_i;
    end
  end

  assign pcW_o        = r_pcW;
  assign instrW_o     = r_instrW;
  assign rdW_data_o   = r_rdW_data;
  assign rdW_addr_o   = r_rdW_addr;
  assign rdW_wr_ena_o = r_rdW_wr_ena;
  assign misaligned_o = r_misaligned;
  assign tb_update_o  = r_tb_update;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: stimulus pushes expected MEM-WB records,
// a monitor pops and compares them whenever tb_update_o marks a retire.
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  localparam logic [31:0] RESET_PC  = 32'h8000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk, rstn;
  logic        tb_update_i, tb_update_o;
  logic [31:0] pcM, instrM, rdM_data, mem_addr, mem_wdata;
  alu_ctrl_e   op;
  logic [4:0]  rdM_addr;
  logic        rdM_we, mem_we;
  logic [31:0] forw, pcW, instrW, rdW_data;
  logic [4:0]  rdW_addr;
  logic        stall, rdW_we, mis;

  mem_stage_lsu_if #(.XLEN(32)) bus ();

  mem_stage_lsu #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .tb_update_i(tb_update_i), .tb_update_o(tb_update_o),
    .pcM_i(pcM), .instrM_i(instrM), .operationM_i(op),
    .rdM_data_i(rdM_data), .rdM_addr_i(rdM_addr), .rdM_wr_ena_i(rdM_we),
    .memM_wr_ena_i(mem_we), .memM_addr_i(mem_addr), .memM_wr_data_i(mem_wdata),
    .forwM_data_o(forw), .stall_o(stall), .dmem(bus.master),
    .pcW_o(pcW), .instrW_o(instrW), .rdW_data_o(rdW_data),
    .rdW_addr_o(rdW_addr), .rdW_wr_ena_o(rdW_we), .misaligned_o(mis)
  );

  typedef struct {
    logic [31:0] pc, instr, data;
    logic [4:0]  rd;
    logic        wena, mis;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] pc_cnt = 32'h0000_0100;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
    end
  endtask

  task automatic idle();
    op = ALU_ADD; pcM = RESET_PC; instrM = NOP_INSTR; rdM_data = '0; rdM_addr = '0;
    rdM_we = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; tb_update_i = 1'b0;
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
  endtask

  // Monitor: every retire flagged by tb_update_o is matched against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn && tb_update_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_retire pc", pcW, 32'hxxxx_xxxx);
        end else begin
          e = sb.pop_front();
          chk("wb pc", pcW, e.pc);
          chk("wb instr", instrW, e.instr);
          chk("wb data", rdW_data, e.data);
          chk("wb rd", {27'h0, rdW_addr}, {27'h0, e.rd});
          chk("wb wena", {31'h0, rdW_we}, {31'h0, e.wena});
          chk("wb misaligned", {31'h0, mis}, {31'h0, e.mis});
        end
      end
    end
  end

  task automatic run_op(input string name, input alu_ctrl_e o, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rdat, input logic [31:0] rdd,
                        input logic [4:0] rd, input logic we, input int gnt_d, input int rsp_d,
                        input logic exp_req, input logic [3:0] exp_wstrb,
                        input logic [31:0] exp_wdata, input int exp_stalls,
                        input logic [31:0] exp_data, input logic exp_wena, input logic exp_mis);
    int   c, stalls;
    bit   done, is_ld, is_st;
    exp_t e;
    is_ld = o inside {ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU};
    is_st = o inside {ALU_SB, ALU_SH, ALU_SW};
    pc_cnt += 4;
    op = o; pcM = pc_cnt; instrM = pc_cnt ^ 32'h00AB_0003; rdM_data = rdd; rdM_addr = rd;
    rdM_we = we; mem_we = is_st; mem_addr = addr; mem_wdata = wd; tb_update_i = 1'b1;
    bus.rdata = rdat;
    e.pc = pcM; e.instr = instrM; e.data = exp_data; e.rd = rd; e.wena = exp_wena; e.mis = exp_mis;
    sb.push_back(e);
    c = 0; stalls = 0; done = 0;
    while (!done && c < 20) begin
      bus.gnt    = (c == gnt_d);
      bus.rvalid = is_ld && (c == gnt_d + rsp_d);
      @(negedge clk);
      if (c == 0) chk({name, " req"}, {31'h0, bus.req}, {31'h0, exp_req});
      if (c > 0) begin
        chk({name, " bubble instr"}, instrW, NOP_INSTR);
        chk({name, " bubble wena"}, {31'h0, rdW_we}, 32'h0);
      end
      if (exp_req && c <= gnt_d) chk({name, " addr"}, bus.addr, {addr[31:2], 2'b00});
      if (exp_req && c == gnt_d) begin
        chk({name, " wstrb"}, {28'h0, bus.wstrb}, {28'h0, exp_wstrb});
        chk({name, " we"}, {31'h0, bus.we}, {31'h0, is_st});
        if (exp_wstrb != 4'b0000) chk({name, " wdata"}, bus.wdata, exp_wdata);
      end
      if (stall) stalls++;
      else       done = 1;
      @(posedge clk); #1;
      c++;
    end
    if (!done) chk({name, " timeout"}, 32'h1, 32'h0);
    chk({name, " stall cycles"}, stalls, exp_stalls);
    idle();
  endtask

  initial begin
    idle();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset pcW", pcW, RESET_PC);
    chk("reset instrW", instrW, NOP_INSTR);
    chk("reset rdW_data", rdW_data, 32'h0);
    chk("reset wena/mis/tb", {29'h0, rdW_we, mis, tb_update_o}, 32'h0);
    chk("reset req/stall", {30'h0, bus.req, stall}, 32'h0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    //      name   op       addr          wdata         rdata         rd_data       rd  we gnt rsp req wstrb    exp_wdata     st  exp_data      wena mis
    run_op("ADD",  ALU_ADD, 32'h0,        32'h0,        32'h0,        32'h0000_1234, 5, 1, 0, 0, 0, 4'b0000, 32'h0,        0, 32'h0000_1234, 1, 0);
    run_op("LB",   ALU_LB,  32'h0000_1003, 32'h0,       32'h80FF_0000, 32'h0,        6, 1, 0, 1, 1, 4'b0000, 32'h0,        1, 32'hFFFF_FF80, 1, 0);
    run_op("LHU",  ALU_LHU, 32'h0000_2002, 32'h0,       32'hBEEF_1234, 32'h0,        7, 1, 2, 3, 1, 4'b0000, 32'h0,        5, 32'h0000_BEEF, 1, 0);
    run_op("SB",   ALU_SB,  32'h0000_3001, 32'h0000_00A5, 32'h0,      32'h0,        0, 1, 0, 0, 1, 4'b0010, 32'hA5A5_A5A5, 0, 32'h0,        0, 0);
    run_op("LWmis", ALU_LW, 32'h0000_4002, 32'h0,       32'h0,        32'h0000_9999, 8, 1, 0, 1, 0, 4'b0000, 32'h0,        0, 32'h0,        0, 1);
    run_op("SH",   ALU_SH,  32'h0000_3002, 32'h1234_BEEF, 32'h0,      32'h0,        0, 1, 1, 0, 1, 4'b1100, 32'hBEEF_BEEF, 1, 32'h0,        0, 0);
    run_op("LH",   ALU_LH,  32'h0000_0010, 32'h0,       32'h0000_8001, 32'h0,        9, 1, 0, 1, 1, 4'b0000, 32'h0,        1, 32'hFFFF_8001, 1, 0);
    run_op("LBU",  ALU_LBU, 32'h0000_0021, 32'h0,       32'h0000_F000, 32'h0,       10, 1, 0, 2, 1, 4'b0000, 32'h0,        2, 32'h0000_00F0, 1, 0);
    run_op("LHmis", ALU_LH, 32'h0000_0011, 32'h0,       32'h0,        32'h0,        11, 1, 0, 1, 0, 4'b0000, 32'h0,        0, 32'h0,        0, 1);
    run_op("SW",   ALU_SW,  32'h0000_0040, 32'hCAFE_F00D, 32'h0,      32'h0,        0, 0, 0, 0, 1, 4'b1111, 32'hCAFE_F00D, 0, 32'h0,        0, 0);

    // Reset while a load waits for its response, then a stale rvalid
    op = ALU_LW; pcM = 32'h0000_0500; instrM = 32'h0000_2003; rdM_addr = 5'd12; rdM_we = 1'b1;
    mem_addr = 32'h0000_5000; tb_update_i = 1'b1; bus.gnt = 1'b1;
    @(negedge clk);
    chk("rstmid req", {31'h0, bus.req}, 32'h1);
    @(posedge clk); #1;
    bus.gnt = 1'b0;
    @(negedge clk);
    chk("rstmid waiting stall", {31'h0, stall}, 32'h1);
    @(posedge clk); #1;
    idle();
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1; bus.rvalid = 1'b1; bus.rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rstmid req/stall", {30'h0, bus.req, stall}, 32'h0);
    chk("rstmid pcW", pcW, RESET_PC);
    chk("rstmid instrW", instrW, NOP_INSTR);
    chk("rstmid rdW_data", rdW_data, 32'h0);
    chk("rstmid wena/mis/tb", {29'h0, rdW_we, mis, tb_update_o}, 32'h0);
    @(posedge clk); #1;
    bus.rvalid = 1'b0;
    @(negedge clk);
    chk("rstmid stale rvalid data", rdW_data, 32'h0);
    chk("rstmid stale rvalid wena", {31'h0, rdW_we}, 32'h0);

    repeat (3) @(posedge clk);
    chk("scoreboard drained", sb.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
